mem_responder: RTL and testbench



---
 rtl/mem_map_pkg.sv | 41 ++++
 rtl/seg7_decode.sv | 30 +++
 rtl/mem_responder.sv | 174 +++++++++++++++++
 tb/tb_mem_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Address map, FSM states and decode helper shared by the memory responder.
package mem_map_pkg;

  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] LEDR_ADDR = 16'h1000;
  localparam logic [15:0] HEX_BASE  = 16'h2000;
  localparam logic [15:0] SW_ADDR   = 16'h3000;

  localparam int NUM_HEX = 6;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    REG_NONE = 3'd0,
    REG_RAM  = 3'd1,
    REG_LEDR = 3'd2,
    REG_HEX  = 3'd3,
    REG_SW   = 3'd4
  } region_t;

  // Takes a word address (byte address bits [15:2]); byte-lane bits never matter.
  function automatic region_t decode_region(input logic [13:0] wa);
    region_t r;
    r = REG_NONE;
    if (wa[13:10] == RAM_BASE[15:12])
      r = REG_RAM;
    else if (wa == LEDR_ADDR[15:2])
      r = REG_LEDR;
    else if (wa[13:3] == HEX_BASE[15:5] && wa[2:0] < 3'(NUM_HEX))
      r = REG_HEX;
    else if (wa == SW_ADDR[15:2])
      r = REG_SW;
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex digit to active-low seven-segment glyph, segment order {g,f,e,d,c,b,a}.
module seg7_decode (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Slave end of the 32-bit processor memory bus: word RAM plus LED, seven-segment
// and switch registers, with waitrequest stretching each transfer by a fixed latency.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 0
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [31:0] Addr,
  input  logic [31:0] DOUT,
  input  logic [3:0]  byteenable,
  input  logic        read,
  input  logic        write,
  output logic [31:0] DIN,
  output logic        waitrequest,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  localparam int RAM_WORDS = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] WR_LAT_C = CNT_W'(WR_LAT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             req;
  logic             accept;

  logic [15:2]      addr_p0;
  logic [31:0]      wdata_p0;
  logic [3:0]       be_p0;
  logic             wr_p0;
  logic             drop_p0;
  logic [31:0]      rdata_p1;

  logic [31:0]      ram [RAM_WORDS];
  logic [ADDR_W-1:0] ram_idx;
  region_t          region;
  logic             commit;
  logic [31:0]      rd_mux;

  logic [3:0]       digit [NUM_HEX];
  logic [6:0]       glyph [NUM_HEX];

  logic             unused_addr;
  assign unused_addr = ^{Addr[31:16], Addr[1:0]};

  assign req    = read | write;
  assign accept = (state == IDLE) && req;
  assign region = decode_region(addr_p0);
  assign commit = (state == ACK) && wr_p0 && !drop_p0;

  // Held in reset, no request is considered pending.
  assign waitrequest = Resetn && req && (state != ACK);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_p0   <= 1'b0;
      drop_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        wr_p0   <= write;
        drop_p0 <= 1'b0;
      end else if (state == BUSY && !req) begin
        drop_p0 <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt   = write ? WR_LAT_C : RD_LAT_C;
          state_nxt = (cnt_nxt != '0) ? BUSY : ACK;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1))
          state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request captured on acceptance
  always_ff @(posedge Clock) begin
    if (accept) begin
      addr_p0  <= Addr[15:2];
      wdata_p0 <= DOUT;
      be_p0    <= byteenable;
    end
  end

  // While idle the RAM is addressed straight from the bus so zero-latency reads
  // still have their word registered by the time ACK is reached.
  assign ram_idx = (state == IDLE) ? Addr[ADDR_W+1:2] : addr_p0[ADDR_W+1:2];

  // Stage p1: synchronous RAM read and byte-lane write
  always_ff @(posedge Clock) begin
    if (commit && region == REG_RAM) begin
      for (int i = 0; i < 4; i++)
        if (be_p0[i])
          ram[ram_idx][8*i +: 8] <= wdata_p0[8*i +: 8];
    end
    rdata_p1 <= ram[ram_idx];
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      LEDR <= '0;
      for (int i = 0; i < NUM_HEX; i++)
        digit[i] <= 4'h0;
    end else if (commit) begin
      if (region == REG_LEDR && (be_p0[0] || be_p0[1]))
        LEDR <= wdata_p0[9:0];
      if (region == REG_HEX) begin
        for (int i = 0; i < NUM_HEX; i++)
          if (addr_p0[4:2] == 3'(i))
            digit[i] <= wdata_p0[3:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_HEX; g++) begin : g_hex
    seg7_decode u_dec (
      .digit (digit[g]),
      .seg   (glyph[g])
    );
  end

  assign HEX0 = glyph[0];
  assign HEX1 = glyph[1];
  assign HEX2 = glyph[2];
  assign HEX3 = glyph[3];
  assign HEX4 = glyph[4];
  assign HEX5 = glyph[5];

  always_comb begin
    rd_mux = '0;
    case (region)
      REG_RAM:  rd_mux = rdata_p1;
      REG_LEDR: rd_mux = {22'b0, LEDR};
      REG_HEX: begin
        for (int i = 0; i < NUM_HEX; i++)
          if (addr_p0[4:2] == 3'(i))
            rd_mux = {25'b0, glyph[i]};
      end
      REG_SW:   rd_mux = {22'b0, SW};
      default:  rd_mux = '0;
    endcase
  end

  // A collision of read and write is treated as a write, so it returns zero too.
  assign DIN = (state == ACK && !wr_p0) ? rd_mux : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, reset corner cases and a
// randomized run against an address-map level model.
module tb_mem_responder;

  localparam int RD_LAT = 1;
  localparam int WR_LAT = 0;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [31:0] Addr, DOUT, DIN;
  logic [3:0]  byteenable;
  logic        read, write, waitrequest;
  logic [9:0]  SW, LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  always #5 Clock = ~Clock;

  mem_responder #(.ADDR_W(10), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .Clock(Clock), .Resetn(Resetn), .Addr(Addr), .DOUT(DOUT),
    .byteenable(byteenable), .read(read), .write(write), .DIN(DIN),
    .waitrequest(waitrequest), .SW(SW), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: first 16 RAM words, LED register, six hex digits.
  logic [31:0] m_ram [16];
  logic [9:0]  m_ledr;
  logic [3:0]  m_dig [6];

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [9:0]  sw;
    int          exp_waits;
    logic [31:0] exp_din;
    logic [9:0]  exp_ledr;
    int          hx;
    logic [6:0]  exp_hex;
    string       nm;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [9:0] sw, input int ew,
                     input logic [31:0] ed, input logic [9:0] el, input int hx,
                     input logic [6:0] eh, input string nm);
    vec_t v;
    v = '{r, w, a, d, be, sw, ew, ed, el, hx, eh, nm};
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [41:0] hex_all();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  function automatic logic [6:0] hex_of(input int i);
    case (i)
      0: return HEX0;
      1: return HEX1;
      2: return HEX2;
      3: return HEX3;
      4: return HEX4;
      default: return HEX5;
    endcase
  endfunction

  function automatic logic [41:0] m_hex_all();
    logic [41:0] v;
    for (int i = 0; i < 6; i++) v[7*i +: 7] = GLYPH[m_dig[i]];
    return v;
  endfunction

  // Reference behaviour of one transfer, from the address map rules.
  task automatic model_xfer(input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be,
                            input logic [9:0] sw,
                            output int exp_waits, output logic [31:0] exp_din);
    logic [15:0] wa;
    int          idx;
    wa        = {a[15:2], 2'b00};
    idx       = int'(wa[11:2]);
    exp_waits = 1 + (w ? WR_LAT : RD_LAT);
    exp_din   = '0;
    if (w) begin
      if (wa < 16'h1000) begin
        if (idx < 16)
          for (int b = 0; b < 4; b++)
            if (be[b]) m_ram[idx][8*b +: 8] = d[8*b +: 8];
      end else if (wa == 16'h1000) begin
        if (be[0] || be[1]) m_ledr = d[9:0];
      end else if (wa >= 16'h2000 && wa <= 16'h2014) begin
        m_dig[(wa - 16'h2000) / 4] = d[3:0];
      end
    end else if (r) begin
      if (wa < 16'h1000)
        exp_din = (idx < 16) ? m_ram[idx] : 32'h0;
      else if (wa == 16'h1000)
        exp_din = {22'b0, m_ledr};
      else if (wa >= 16'h2000 && wa <= 16'h2014)
        exp_din = {25'b0, GLYPH[m_dig[(wa - 16'h2000) / 4]]};
      else if (wa == 16'h3000)
        exp_din = {22'b0, sw};
    end
  endtask

  // Called just after a rising edge; returns just after the edge that ends ACK.
  task automatic xfer(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output int waits, output logic [31:0] din);
    bit done;
    done  = 1'b0;
    waits = 0;
    din   = '0;
    read = r; write = w; Addr = a; DOUT = d; byteenable = be;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge Clock);
      if (!waitrequest) begin
        din  = DIN;
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    @(posedge Clock); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic run_model_vec(input bit r, input bit w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] be,
                               input logic [9:0] sw, input string nm);
    int          ew, gw;
    logic [31:0] ed, gd;
    SW = sw;
    model_xfer(r, w, a, d, be, sw, ew, ed);
    xfer(r, w, a, d, be, gw, gd);
    chk({nm, "_waits"}, 64'(gw), 64'(ew));
    chk({nm, "_din"}, 64'(gd), 64'(ed));
    chk({nm, "_ledr"}, 64'(LEDR), 64'(m_ledr));
    chk({nm, "_hex"}, 64'(hex_all()), 64'(m_hex_all()));
  endtask

  initial begin
    int          gw, ew;
    logic [31:0] gd, ed;

    //            r  w  addr          data          be    sw      wt din           ledr    hx hex   name
    add(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 10'h0,   1, 32'h0,        10'h0,   2, 7'h40, "ram_wr");
    add(1, 0, 32'h0000_0010, 32'h0,         4'h0, 10'h0,   2, 32'hDEAD_BEEF, 10'h0,  2, 7'h40, "ram_rd");
    add(0, 1, 32'h0000_0010, 32'h1122_3344, 4'h5, 10'h0,   1, 32'h0,        10'h0,   2, 7'h40, "be_wr");
    add(1, 0, 32'h0000_0010, 32'h0,         4'h0, 10'h0,   2, 32'hDE22_BE44, 10'h0,  2, 7'h40, "be_rd");
    add(0, 1, 32'h0000_1000, 32'h0000_03FF, 4'hF, 10'h0,   1, 32'h0,        10'h3FF, 2, 7'h40, "ledr_wr");
    add(1, 0, 32'h0000_1000, 32'h0,         4'h0, 10'h0,   2, 32'h3FF,      10'h3FF, 2, 7'h40, "ledr_rd");
    add(0, 1, 32'h0000_2008, 32'h0000_0005, 4'hF, 10'h0,   1, 32'h0,        10'h3FF, 2, 7'h12, "hex2_wr");
    add(1, 0, 32'h0000_2008, 32'h0,         4'h0, 10'h0,   2, 32'h12,       10'h3FF, 2, 7'h12, "hex2_rd");
    add(1, 0, 32'h0000_3000, 32'h0,         4'h0, 10'h2A,  2, 32'h2A,       10'h3FF, 2, 7'h12, "sw_rd");
    add(1, 0, 32'h0000_4000, 32'h0,         4'h0, 10'h0,   2, 32'h0,        10'h3FF, 2, 7'h12, "unmap_rd");
    add(1, 1, 32'h0000_0014, 32'hCAFE_F00D, 4'hF, 10'h0,   1, 32'h0,        10'h3FF, 2, 7'h12, "rw_both");
    add(1, 0, 32'h0000_0014, 32'h0,         4'h0, 10'h0,   2, 32'hCAFE_F00D, 10'h3FF, 2, 7'h12, "rw_both_rd");
    add(0, 1, 32'h0000_3000, 32'hFFFF_FFFF, 4'hF, 10'h0,   1, 32'h0,        10'h3FF, 2, 7'h12, "sw_wr");
    add(1, 0, 32'h0000_3000, 32'h0,         4'h0, 10'h155, 2, 32'h155,      10'h3FF, 2, 7'h12, "sw_rd2");
    add(0, 1, 32'h0000_4000, 32'h1234_5678, 4'hF, 10'h0,   1, 32'h0,        10'h3FF, 2, 7'h12, "unmap_wr");
    add(1, 0, 32'h0000_0010, 32'h0,         4'h0, 10'h0,   2, 32'hDE22_BE44, 10'h3FF, 2, 7'h12, "ram_keep");
    add(0, 1, 32'h0000_1000, 32'h0,         4'hC, 10'h0,   1, 32'h0,        10'h3FF, 2, 7'h12, "ledr_hi_be");
    add(1, 0, 32'hABCD_0013, 32'h0,         4'h0, 10'h0,   2, 32'hDE22_BE44, 10'h3FF, 2, 7'h12, "addr_alias");
    add(0, 1, 32'h0000_2014, 32'h0000_000A, 4'h1, 10'h0,   1, 32'h0,        10'h3FF, 5, 7'h08, "hex5_wr");
    add(1, 0, 32'h0000_2014, 32'h0,         4'h0, 10'h0,   2, 32'h08,       10'h3FF, 5, 7'h08, "hex5_rd");

    m_ledr = '0;
    for (int i = 0; i < 6; i++) m_dig[i] = 4'h0;

    // Reset with a read already asserted.
    Resetn = 1'b0; read = 1'b1; write = 1'b0; Addr = 32'h10; DOUT = '0;
    byteenable = '0; SW = '0;
    repeat (2) @(negedge Clock);
    chk("rst_waitreq", 64'(waitrequest), 64'h0);
    chk("rst_din", 64'(DIN), 64'h0);
    chk("rst_ledr", 64'(LEDR), 64'h0);
    chk("rst_hex", 64'(hex_all()), 64'({6{7'h40}}));
    read = 1'b0;
    Resetn = 1'b1;
    @(posedge Clock); #1;

    foreach (tv[i]) begin
      SW = tv[i].sw;
      model_xfer(tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].be, tv[i].sw, ew, ed);
      xfer(tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].be, gw, gd);
      chk({tv[i].nm, "_waits"}, 64'(gw), 64'(tv[i].exp_waits));
      chk({tv[i].nm, "_din"}, 64'(gd), 64'(tv[i].exp_din));
      chk({tv[i].nm, "_ledr"}, 64'(LEDR), 64'(tv[i].exp_ledr));
      chk({tv[i].nm, "_hex"}, 64'(hex_of(tv[i].hx)), 64'(tv[i].exp_hex));
    end

    // Reset pulled during the ACK of an LED write: nothing may commit.
    write = 1'b1; read = 1'b0; Addr = 32'h1000; DOUT = 32'h2AA; byteenable = 4'hF;
    @(negedge Clock);
    chk("rstmid_wait", 64'(waitrequest), 64'h1);
    @(negedge Clock);
    chk("rstmid_ack", 64'(waitrequest), 64'h0);
    #1 Resetn = 1'b0;
    @(posedge Clock); #1;
    write = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    m_ledr = '0;
    for (int i = 0; i < 6; i++) m_dig[i] = 4'h0;
    chk("rstmid_ledr", 64'(LEDR), 64'h0);
    chk("rstmid_hex", 64'(hex_all()), 64'(m_hex_all()));
    chk("rstmid_idle_wr", 64'(waitrequest), 64'h0);
    @(posedge Clock); #1;
    run_model_vec(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 10'h0, "rstmid_rd");

    // Give the modelled RAM window known contents.
    for (int w = 0; w < 16; w++)
      run_model_vec(1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF, 10'h0, $sformatf("init%0d", w));

    for (int i = 0; i < 300; i++) begin
      int          k, p;
      logic [31:0] a, u;
      bit          r, w;
      k = $urandom_range(0, 9);
      u = $urandom;
      case (k)
        0, 1, 2, 3, 9: a = {u[31:16], 4'h0, 6'h0, 4'($urandom_range(0, 15)), u[1:0]};
        4:             a = {u[31:16], 16'h1000 | {14'h0, u[1:0]}};
        5, 6:          a = {u[31:16], 16'(16'h2000 + 16'($urandom_range(0, 5)) * 16'd4)};
        7:             a = {u[31:16], 16'h3000};
        default:       a = u[2] ? 32'h0000_2018 : {u[31:16], 2'b01, u[13:2], 2'b00};
      endcase
      p = $urandom_range(0, 9);
      r = (p <= 3) || (p == 9);
      w = (p >= 4);
      run_model_vec(r, w, a, $urandom, 4'($urandom_range(0, 15)),
                    10'($urandom_range(0, 1023)), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
